// File: rtl/patp_sequencer_if.sv
// Interface bundling the PATP sequencer's control inputs and phase/timing outputs.
// The sequencer connects through the slave modport; the control side uses master.
interface patp_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [2:0]       ir_opcode;
  logic             start_execute;
  logic             start_fetch;
  logic             fetch;
  logic             clear;
  logic             inc1;
  logic             add;
  logic             dec1;
  logic             jmp;
  logic             buz;
  logic             load;
  logic             store;
  logic             t1;
  logic             t2;
  logic             t3;
  logic             t4;
  logic             t5;
  logic [CNT_W-1:0] instr_count;
  logic             seq_error;

  modport slave (
    input  run, ir_opcode, start_execute, start_fetch,
    output fetch, clear, inc1, add, dec1, jmp, buz, load, store,
    output t1, t2, t3, t4, t5, instr_count, seq_error
  );

  modport master (
    output run, ir_opcode, start_execute, start_fetch,
    input  fetch, clear, inc1, add, dec1, jmp, buz, load, store,
    input  t1, t2, t3, t4, t5, instr_count, seq_error
  );
endinterface

// File: rtl/patp_sequencer.sv
// PATP timing/phase sequencer: fetch/execute phase, one-hot t1..t5, opcode latch,
// retired-instruction counter and sticky overrun flag. All outputs are register-decoded.
module patp_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  patp_sequencer_if.slave  bus
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [4:0]       tstate_q, tstate_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [7:0]       op_lines;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_FETCH;
      tstate_q <= 5'b00001;
      op_q     <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      tstate_q <= tstate_d;
      op_q     <= op_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Handoffs win over the t5 overrun check, so a pulse at t5 is a clean handoff.
  always_comb begin
    phase_d  = phase_q;
    tstate_d = tstate_q;
    op_d     = op_q;
    count_d  = count_q;
    err_d    = err_q;
    if (bus.run) begin
      if (phase_q == PH_FETCH && bus.start_execute) begin
        phase_d  = PH_EXEC;
        tstate_d = 5'b00001;
        op_d     = bus.ir_opcode;
      end else if (phase_q == PH_EXEC && bus.start_fetch) begin
        phase_d  = PH_FETCH;
        tstate_d = 5'b00001;
        count_d  = count_q + CNT_W'(1);
      end else if (tstate_q[4]) begin
        phase_d  = PH_FETCH;
        tstate_d = 5'b00001;
        err_d    = 1'b1;
      end else begin
        tstate_d = {tstate_q[3:0], 1'b0};
      end
    end
  end

  always_comb begin
    op_lines = '0;
    if (phase_q == PH_EXEC) op_lines[op_q] = 1'b1;
  end

  assign bus.fetch       = (phase_q == PH_FETCH);
  assign bus.clear       = op_lines[0];
  assign bus.inc1        = op_lines[1];
  assign bus.add         = op_lines[2];
  assign bus.dec1        = op_lines[3];
  assign bus.jmp         = op_lines[4];
  assign bus.buz         = op_lines[5];
  assign bus.load        = op_lines[6];
  assign bus.store       = op_lines[7];
  assign bus.t1          = tstate_q[0];
  assign bus.t2          = tstate_q[1];
  assign bus.t3          = tstate_q[2];
  assign bus.t4          = tstate_q[3];
  assign bus.t5          = tstate_q[4];
  assign bus.instr_count = count_q;
  assign bus.seq_error   = err_q;

endmodule

// File: tb/tb_patp_sequencer.sv
// Scoreboard bench for patp_sequencer: the driver pushes model predictions per cycle,
// a monitor pops and compares them against the DUT outputs after each rising edge.
module tb_patp_sequencer;
  localparam int CW = 4;

  logic clk;
  logic rst;

  patp_sequencer_if #(.CNT_W(CW)) bus ();

  patp_sequencer #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          fetch;
    logic [7:0]    lines;
    logic [4:0]    t;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: phase as a flag, timing state as an integer 1..5.
  bit m_exec;
  int m_ts;
  int m_op;
  int m_cnt;
  bit m_err;

  task automatic model_reset();
    m_exec = 0; m_ts = 1; m_op = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic step(input bit r, input bit rn, input bit se, input bit sf, input int op);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.run = rn;
    bus.start_execute = se;
    bus.start_fetch = sf;
    bus.ir_opcode = 3'(op);
    if (r) begin
      model_reset();
    end else if (rn) begin
      if (!m_exec && se) begin
        m_exec = 1; m_ts = 1; m_op = op;
      end else if (m_exec && sf) begin
        m_exec = 0; m_ts = 1; m_cnt = (m_cnt + 1) % (1 << CW);
      end else if (m_ts == 5) begin
        m_exec = 0; m_ts = 1; m_err = 1;
      end else begin
        m_ts = m_ts + 1;
      end
    end
    e.fetch = !m_exec;
    e.lines = m_exec ? 8'(1 << m_op) : 8'h00;
    e.t     = 5'(1 << (m_ts - 1));
    e.cnt   = CW'(m_cnt);
    e.err   = m_err;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, int'($urandom_range(0, 7)));
  endtask

  // One instruction: start_execute at fetch t5, start_fetch at execute tstate elen.
  task automatic run_instr(input int op, input int elen);
    for (int i = 0; i < 6 && !(!m_exec && m_ts == 5); i++) idle();
    step(0, 1, 1, 0, op);
    for (int i = 0; i < 6 && m_ts != elen; i++) idle();
    step(0, 1, 0, 1, int'($urandom_range(0, 7)));
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("fetch", 16'(bus.fetch), 16'(e.fetch));
      check("oplines", 16'({bus.store, bus.load, bus.buz, bus.jmp,
                            bus.dec1, bus.add, bus.inc1, bus.clear}), 16'(e.lines));
      check("tstate", 16'({bus.t5, bus.t4, bus.t3, bus.t2, bus.t1}), 16'(e.t));
      check("instr_count", 16'(bus.instr_count), 16'(e.cnt));
      check("seq_error", 16'(bus.seq_error), 16'(e.err));
    end
  end

  initial begin
    rst = 1'b1;
    bus.run = 1'b1;
    bus.start_execute = 1'b0;
    bus.start_fetch = 1'b0;
    bus.ir_opcode = 3'd0;
    model_reset();

    // Reset with run high, then with run low
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 5);

    // ADD: 8-cycle instruction
    run_instr(2, 3);
    // JMP with IR changing to 111 during execute; 7-cycle instruction
    for (int i = 0; i < 6 && !(!m_exec && m_ts == 5); i++) idle();
    step(0, 1, 1, 0, 4);
    step(0, 1, 0, 0, 7);
    step(0, 1, 0, 1, 7);

    // Stall at execute t2 with start_fetch held
    for (int i = 0; i < 6 && !(!m_exec && m_ts == 5); i++) idle();
    step(0, 1, 1, 0, 1);
    idle();
    repeat (3) step(0, 0, 0, 1, 3);
    step(0, 1, 0, 1, 3);

    // Overrun: no start_execute through fetch t5
    repeat (5) idle();
    // start_fetch during fetch t3 is ignored
    idle(); idle();
    step(0, 1, 0, 1, 0);
    // Both pulses at execute t2: only start_fetch taken
    for (int i = 0; i < 6 && !(!m_exec && m_ts == 5); i++) idle();
    step(0, 1, 1, 0, 6);
    idle();
    step(0, 1, 1, 1, 2);
    run_instr(0, 3);

    // Counter wrap from all-ones
    step(1, 1, 0, 0, 0);
    for (int n = 0; n < (1 << CW); n++) run_instr(int'($urandom_range(0, 7)), 3);
    run_instr(5, 2);
    // Reset mid-execute at t2
    for (int i = 0; i < 6 && !(!m_exec && m_ts == 5); i++) idle();
    step(0, 1, 1, 0, 3);
    idle();
    step(1, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 7)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
